// File: rtl/prio_pkg.sv
// Shared helpers for one-hot priority logic: width derivation and one-hot to binary encode.
package prio_pkg;
  localparam int MAXW  = 1024;
  localparam int MAXIW = 10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Callers zero-extend their one-hot vector to MAXW and truncate the result to their own index width.
  function automatic logic [MAXIW-1:0] onehot2bin(input logic [MAXW-1:0] oh);
    logic [MAXIW-1:0] b;
    b = '0;
    for (int i = 0; i < MAXW; i++)
      if (oh[i]) b = b | MAXIW'(i);
    return b;
  endfunction
endpackage

// File: rtl/prio.sv
// Combinational one-hot priority selector: the highest set index wins.
module prio #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] req,
  output logic [DW-1:0] sel,
  output logic          valid
);
  assign valid = |req;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    if (i == DW-1) begin : g_top
      assign sel[i] = req[i];
    end else begin : g_low
      assign sel[i] = req[i] & ~(|req[DW-1:i+1]);
    end
  end
endmodule

// File: rtl/prio_sched.sv
// Sticky request scheduler: pending vector plus one registered grant slot with valid/ready handshake.
module prio_sched
  import prio_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = clog2(DW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] req_in,
  input  logic [DW-1:0] mask,
  input  logic          flush,
  output logic [DW-1:0] grant,
  output logic [IW-1:0] grant_id,
  output logic          grant_valid,
  input  logic          grant_ready,
  output logic [DW-1:0] pending,
  output logic          busy
);
  logic [DW-1:0] cand, sel;
  logic          sel_any, load;

  assign cand = pending & mask;
  assign load = ~grant_valid | grant_ready;

  prio #(.DW(DW)) u_prio (
    .req   (cand),
    .sel   (sel),
    .valid (sel_any)
  );

  // A same-edge request re-sets the bit being moved into the slot (set beats clear).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending     <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else if (flush) begin
      pending     <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else if (load) begin
      pending     <= (pending & ~sel) | req_in;
      grant       <= sel;
      grant_id    <= IW'(onehot2bin(MAXW'(sel)));
      grant_valid <= sel_any;
    end else begin
      pending     <= pending | req_in;
    end
  end

  assign busy = (|pending) | grant_valid;
endmodule

// File: tb/tb_prio_sched.sv
// Directed and randomized bench for prio_sched (DW=8) against a queue-free arithmetic reference model.
module tb_prio_sched;
  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [DW-1:0] req_in = '0;
  logic [DW-1:0] mask = '1;
  logic          flush = 1'b0;
  logic          grant_ready = 1'b0;
  logic [DW-1:0] grant;
  logic [IW-1:0] grant_id;
  logic          grant_valid;
  logic [DW-1:0] pending;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_pend = 0;
  int m_valid = 0;
  int m_id = 0;

  prio_sched #(.DW(DW)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req_in      (req_in),
    .mask        (mask),
    .flush       (flush),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    return m_valid ? (1 << m_id) : 0;
  endfunction

  // Apply inputs for one clock, advance the model by the scheduling rules, sample 1ns after the edge.
  task automatic cycle(input int r, input int m, input int rdy, input int f);
    int cand, hi;
    req_in = DW'(r); mask = DW'(m); grant_ready = rdy[0]; flush = f[0];
    @(posedge clk);
    if (f != 0) begin
      m_pend = 0; m_valid = 0; m_id = 0;
    end else if (m_valid == 0 || rdy != 0) begin
      cand = m_pend & m;
      if (cand != 0) begin
        hi = $clog2(cand + 1) - 1;
        m_pend = (m_pend & ~(1 << hi)) | r;
        m_valid = 1; m_id = hi;
      end else begin
        m_pend = m_pend | r;
        m_valid = 0; m_id = 0;
      end
    end else begin
      m_pend = m_pend | r;
    end
    #1;
    req_in = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    m_pend = 0; m_valid = 0; m_id = 0;
    cycle(0, 'hFF, 0, 0);
    cycle(0, 'hFF, 0, 0);
    checks++;
    if ({grant_valid, grant, grant_id, busy, pending} !== '0) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b grant=%h id=%0d busy=%0b pend=%h, want all 0",
               grant_valid, grant, grant_id, busy, pending);
    end
  endtask

  task automatic test_sequence();
    int exp_g[3] = '{'h20, 'h04, 'h01};
    int exp_i[3] = '{5, 2, 0};
    cycle('h25, 'hFF, 1, 0);
    checks++;
    if (pending !== 8'h25 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_latch: pend=%h valid=%0b, want 25/0", pending, grant_valid);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 'hFF, 1, 0);
      checks++;
      if (grant !== DW'(exp_g[k]) || grant_id !== IW'(exp_i[k]) || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_grant%0d: grant=%h id=%0d valid=%0b, want %h/%0d/1",
                 k, grant, grant_id, grant_valid, exp_g[k], exp_i[k]);
      end
    end
    cycle(0, 'hFF, 1, 0);
    checks++;
    if (pending !== 8'h00 || grant_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_drain: pend=%h valid=%0b busy=%0b, want 00/0/0", pending, grant_valid, busy);
    end
  endtask

  task automatic test_stall();
    cycle('h04, 'hFF, 0, 0);
    cycle(0, 'hFF, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(k == 0 ? 'h80 : 0, 'hFF, 0, 0);
      checks++;
      if (grant !== 8'h04 || grant_id !== 3'd2 || grant_valid !== 1'b1 || pending !== 8'h80) begin
        errors++;
        $display("FAIL stall_hold%0d: grant=%h id=%0d pend=%h, want 04/2/80", k, grant, grant_id, pending);
      end
    end
    cycle(0, 'hFF, 1, 0);
    checks++;
    if (grant !== 8'h80 || grant_id !== 3'd7 || pending !== 8'h00) begin
      errors++;
      $display("FAIL stall_release: grant=%h id=%0d pend=%h, want 80/7/00", grant, grant_id, pending);
    end
    cycle(0, 'hFF, 1, 0);
    checks++;
    if (grant_valid !== 1'b0 || grant !== 8'h00 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL stall_drain: valid=%0b grant=%h id=%0d, want 0/00/0", grant_valid, grant, grant_id);
    end
  endtask

  task automatic test_mask();
    cycle('h0F, 'hF0, 1, 0);
    cycle(0, 'hF0, 1, 0);
    checks++;
    if (pending !== 8'h0F || grant_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mask_block: pend=%h valid=%0b busy=%0b, want 0F/0/1", pending, grant_valid, busy);
    end
    cycle(0, 'hFF, 1, 0);
    checks++;
    if (grant !== 8'h08 || grant_id !== 3'd3 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL mask_open: grant=%h id=%0d valid=%0b, want 08/3/1", grant, grant_id, grant_valid);
    end
    repeat (4) cycle(0, 'hFF, 1, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mask_drain: busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_rerequest();
    int ngrants;
    cycle('h08, 'hFF, 1, 0);
    cycle(0, 'hFF, 0, 0);
    cycle('h08, 'hFF, 1, 0);
    checks++;
    if (pending !== 8'h08 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL rereq_set: pend=%h valid=%0b, want 08/0", pending, grant_valid);
    end
    cycle(0, 'hFF, 0, 0);
    checks++;
    if (grant !== 8'h08 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL rereq_regrant: grant=%h valid=%0b, want 08/1", grant, grant_valid);
    end
    repeat (3) cycle('h08, 'hFF, 0, 0);
    ngrants = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 'hFF, 1, 0);
      if (grant_valid === 1'b1 && grant === 8'h08) ngrants++;
    end
    checks++;
    if (ngrants != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rereq_coalesce: extra grants=%0d busy=%0b, want 1/0", ngrants, busy);
    end
  endtask

  task automatic test_flush();
    cycle('hC3, 'hFF, 0, 0);
    cycle(0, 'hFF, 0, 0);
    cycle('h80, 'hFF, 0, 0);
    checks++;
    if (pending !== 8'hC3 || grant !== 8'h80 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: pend=%h grant=%h valid=%0b, want C3/80/1", pending, grant, grant_valid);
    end
    cycle('h01, 'hFF, 1, 1);
    checks++;
    if (pending !== 8'h00 || grant_valid !== 1'b0 || grant !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: pend=%h valid=%0b grant=%h busy=%0b, want 00/0/00/0",
               pending, grant_valid, grant, busy);
    end
    cycle(0, 'hFF, 1, 0);
    checks++;
    if (grant_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL flush_lost: valid=%0b pend=%h, want 0/00", grant_valid, pending);
    end
  endtask

  task automatic test_async_reset();
    cycle('h30, 'hFF, 0, 0);
    cycle(0, 'hFF, 0, 0);
    cycle(0, 'hFF, 0, 0);
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({grant_valid, grant, grant_id, busy, pending} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b grant=%h id=%0d busy=%0b pend=%h, want all 0",
               grant_valid, grant, grant_id, busy, pending);
    end
    m_pend = 0; m_valid = 0; m_id = 0;
    #1 nreset = 1'b1;
  endtask

  task automatic test_random();
    int r, m, rdy, f;
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0;
      m   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : 'hFF;
      rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
      f   = ($urandom_range(0, 40) == 0) ? 1 : 0;
      cycle(r, m, rdy, f);
      checks++;
      if (grant !== DW'(m_grant()) || grant_id !== IW'(m_id) || grant_valid !== m_valid[0] ||
          pending !== DW'(m_pend) || busy !== (m_pend != 0 || m_valid != 0)) begin
        errors++;
        $display("FAIL rand%0d: grant=%h id=%0d valid=%0b pend=%h busy=%0b, want %h/%0d/%0d/%h/%0b",
                 k, grant, grant_id, grant_valid, pending, busy, m_grant(), m_id, m_valid, m_pend,
                 (m_pend != 0 || m_valid != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_mask();
    test_rerequest();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
